// File: rtl/mem_access_pkg.sv
// Shared constants, bus layouts and FSM encoding for the memory-access stage.
// Bus structs mirror the EX->MEM and MEM->WB bit layouts field for field.
package mem_access_pkg;

    localparam int EX_TO_MEM_WD = 243;
    localparam int MEM_TO_WB_WD = 174;
    localparam int FWD_WD       = 38;
    localparam int STALL_WD     = 6;
    localparam int STALL_OWN    = 3;
    localparam int STALL_DOWN   = 4;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] badvaddr;
        logic        is_in_delayslot;
        logic [4:0]  excepttype;
        logic        lo_we;
        logic [31:0] lo_wdata;
        logic        hi_we;
        logic [31:0] hi_wdata;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef struct packed {
        logic        mem_en;
        logic        mem_we;
        logic [1:0]  mem_size;
        logic        mem_sign;
        logic [31:0] mem_addr;
        logic [31:0] st_data;
        mem_to_wb_t  payload;
    } ex_to_mem_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SIZE_HALF) && addr_lo[0]) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

    // True when the instruction will actually drive an SRAM transaction.
    function automatic logic access_valid(input ex_to_mem_t ins);
        return ins.mem_en && !misaligned(ins.mem_size, ins.mem_addr[1:0]) &&
               (ins.payload.excepttype == EXC_NONE);
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Picks the addressed byte/half lane out of the returned load word and
// sign- or zero-extends it to 32 bits.
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] ld_r,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first, or a default arm), otherwise a latch is inferred.
    always_comb begin
        unique case (addr)
            2'd0:    byte_lane = ld_r[7:0];
            2'd1:    byte_lane = ld_r[15:8];
            2'd2:    byte_lane = ld_r[23:16];
            default: byte_lane = ld_r[31:24];
        endcase
        half_lane = addr[1] ? ld_r[31:16] : ld_r[15:0];

        unique case (size)
            SIZE_BYTE: result = {{24{sign & byte_lane[7]}}, byte_lane};
            SIZE_HALF: result = {{16{sign & half_lane[15]}}, half_lane};
            default:   result = ld_r;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: registers the EX->MEM bus, checks alignment,
// runs one SRAM request/response per instruction and formats the WB bus.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [FWD_WD-1:0]       mem_to_id_fwd,
    output logic                    stallreq_for_mem,
    output logic                    data_req,
    output logic                    data_wr,
    output logic [1:0]              data_size,
    output logic [31:0]             data_addr,
    output logic [31:0]             data_wdata,
    input  logic                    data_addr_ok,
    input  logic                    data_data_ok,
    input  logic [31:0]             data_rdata
);

    ex_to_mem_t incoming;
    ex_to_mem_t r;
    state_t     state;
    state_t     state_nxt;
    logic [31:0] ld_r;
    logic [31:0] ld_result;
    logic        latch_new;
    logic        latch_bubble;
    logic        misalign;
    mem_to_wb_t  wb;
    logic        unused_stall;

    assign incoming     = ex_to_mem_bus;
    assign latch_new    = (stall[STALL_OWN] == NO_STOP);
    assign latch_bubble = (stall[STALL_OWN] == STOP) && (stall[STALL_DOWN] == NO_STOP);
    assign unused_stall = ^{stall[5], stall[2:0]};

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r     <= '0;
            state <= ST_IDLE;
            ld_r  <= '0;
        end else begin
            if (latch_bubble) begin
                r <= '0;
            end else if (latch_new) begin
                r <= incoming;
            end
            state <= state_nxt;
            if ((state == ST_WAIT) && data_data_ok) begin
                ld_r <= data_rdata;
            end
        end
    end

    // Responses outside WAIT belong to nothing we track and are dropped.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (latch_new) begin
                    state_nxt = access_valid(incoming) ? ST_REQ : ST_IDLE;
                end else if (latch_bubble) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_REQ:  if (data_addr_ok) state_nxt = ST_WAIT;
            ST_WAIT: if (data_data_ok) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign stallreq_for_mem = (state == ST_REQ) || (state == ST_WAIT);
    assign data_req         = (state == ST_REQ);
    assign data_wr          = r.mem_we;
    assign data_size        = r.mem_size;
    assign data_addr        = r.mem_addr;

    always_comb begin
        unique case (r.mem_size)
            SIZE_BYTE: data_wdata = {4{r.st_data[7:0]}};
            SIZE_HALF: data_wdata = {2{r.st_data[15:0]}};
            default:   data_wdata = r.st_data;
        endcase
    end

    mem_access_load_align u_load_align (
        .ld_r   (ld_r),
        .addr   (r.mem_addr[1:0]),
        .size   (r.mem_size),
        .sign   (r.mem_sign),
        .result (ld_result)
    );

    assign misalign = r.mem_en && misaligned(r.mem_size, r.mem_addr[1:0]);

    always_comb begin
        wb = r.payload;
        if (misalign) begin
            wb.excepttype = r.mem_we ? EXC_ADES : EXC_ADEL;
            wb.badvaddr   = r.mem_addr;
            wb.rf_we      = 1'b0;
        end
        if ((state == ST_DONE) && !r.mem_we) begin
            wb.rf_wdata = ld_result;
        end
    end

    assign mem_to_wb_bus = wb;
    // Bypass must not advertise a load result before the data has returned.
    assign mem_to_id_fwd = {wb.rf_we & ~stallreq_for_mem, wb.rf_waddr, wb.rf_wdata};

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage between EX and WB. Registers the EX→MEM bus under the pipeline stall vector and detects load/store address misalignment. Issues at most one data-SRAM transaction per instruction over a request/response handshake, holding the pipeline until it completes. Aligns and extends load data and produces the MEM→WB bus and a MEM→ID forwarding bus.

## Interface
Parameters:
- `EX_TO_MEM_WD`, 243: `{mem_en, mem_we, mem_size[1:0], mem_sign, mem_addr[31:0], st_data[31:0], payload[173:0]}`. `payload` has the MEM→WB layout.
- `MEM_TO_WB_WD`, 174: `{badvaddr[173:142], is_in_delayslot[141], excepttype[140:136], lo_we, lo_wdata, hi_we, hi_wdata, pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}`.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset: asynchronous, active-low (asserted at 0).
- `stall`  in  `StallBus`(6)  pipeline stall vector; this stage uses `stall[3]` (own) and `stall[4]` (downstream).
- `ex_to_mem_bus`  in  `EX_TO_MEM_WD`  instruction from EX.
- `mem_to_wb_bus`  out  `MEM_TO_WB_WD`  result to WB.
- `mem_to_id_fwd`  out  38  `{rf_we, rf_waddr, rf_wdata}` for bypass; `rf_we` is 0 while a load is unresolved.
- `stallreq_for_mem`  out  1  pipeline hold request.
- `data_req`  out  1  SRAM request valid.
- `data_wr`  out  1  1 = store.
- `data_size`  out  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  out  32  byte address.
- `data_wdata`  out  32  lane-replicated store data.
- `data_addr_ok`  in  1  request accepted.
- `data_data_ok`  in  1  response / store completion.
- `data_rdata`  in  32  load data (aligned word).

## Operation
- Input register: on reset, clear to 0. If `stall[3]`=Stop and `stall[4]`=NoStop, load 0 (bubble). Else if `stall[3]`=NoStop, load `ex_to_mem_bus`. Else hold.
- Misalignment:
  - half access with `addr[0]`≠0, or word access with `addr[1:0]`≠0.
  - Load sets `excepttype`=0x04, store sets 0x05; `badvaddr`=`mem_addr`.
  - No SRAM access is made; `rf_we` is forced to 0.
- An incoming nonzero `excepttype` also suppresses the access.
- FSM states:
  - IDLE: go to REQ on latching `mem_en`=1 with no exception.
  - REQ: `data_req`=1. On `data_addr_ok`, go to WAIT.
  - WAIT: on `data_data_ok`, capture `data_rdata` into `ld_r` and go to DONE.
  - DONE: hold the result. Latching a new valid access goes to REQ; latching anything else goes to IDLE.
- IDLE also goes to REQ from DONE under the same latch condition.
- `stallreq_for_mem` = state ∈ {REQ, WAIT}.
- `data_wdata`: byte gives `{4{st_data[7:0]}}`, half gives `{2{st_data[15:0]}}`, word gives `st_data`.
- Load result: select byte lane `addr[1:0]` or half lane `addr[1]` from `ld_r`. Extend with sign if `mem_sign`, else with zeros. The result replaces `rf_wdata` in DONE.
- Output: `mem_to_wb_bus` = payload with the load/exception fields substituted. A `data_data_ok` arriving in IDLE or DONE is ignored.

## Timing
- Reset: all outputs 0, including `data_req`, `stallreq_for_mem` and both buses; state IDLE.
- Non-memory instruction: 1 cycle in the stage, no stall.
- Memory access: latch at edge N; REQ in cycle N+1.
  - `addr_ok` in the same cycle gives WAIT at N+2.
  - `data_ok` at N+k gives DONE at edge N+k+1; the stall drops in that cycle; WB latches at the following edge.
- `data_addr`, `data_wr`, `data_size` and `data_wdata` stay stable for as long as `data_req`=1.
- Reset asserted mid-transaction: immediate return to IDLE; no pending response is tracked.
- No simultaneous new latch during REQ/WAIT: the hold request guarantees `stall[3]`=Stop.

## Structure
- Shared `defines.vh` gains `EX_TO_MEM_WD`, the size codes and the AdEL/AdES codes.
- The FSM state encoding is local parameters.
- One sub-module: `load_align`, combinational. Inputs: `ld_r`, `addr[1:0]`, `size`, `sign`. Output: 32-bit result.

## Test plan
- `lb` at address 0x…03, sign=1, `rdata`=0x80AA_BBCC → `rf_wdata`=0xFFFF_FF80; `lhu` at 0x…02 with the same data → 0x0000_80AA.
- `sh` of 0x1234 at 0x…02 → `data_wdata`=0x1234_1234, `data_size`=1, `data_wr`=1.
- `addr_ok` delayed 3 cycles and `data_ok` 2 after that → `data_req` held 4 cycles with stable address; stall high until DONE; exactly one WB entry.
- `lw` at 0x…02 → `excepttype`=0x04, `badvaddr`=addr, `data_req` never asserted, no stall.
- `rst`=0 pulsed during WAIT → all outputs 0 immediately; a later stray `data_ok` is ignored.
- Back-to-back load then ALU instruction → the ALU result reaches WB on the cycle after the load result; `mem_to_id_fwd.rf_we`=0 while the load waits.
